register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised two-read/one-write register file with a per-register pending-write scoreboard for the pipelined RISC-V core. It sits between decode (read ports, reservations) and writeback (write port). It holds architectural state and tells decode whether a source operand is still waiting on an in-flight write. Storage is a flop array, not inferred RAM, with asynchronous read and synchronous write.

## Interface
Parameters:
- N, 32: data width in bits.
- L, 5: address width in bits; depth is 2**L.
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_ena  in  1  writeback strobe.
- wr_addr  in  L  writeback destination.
- wr_data  in  N  writeback data.
- rsv_ena  in  1  reserve (mark pending) a destination at issue.
- rsv_addr  in  L  destination being reserved.
- rd_addr0, rd_addr1  in  L  source addresses.
- rd_data0, rd_data1  out  N  source data (combinational).
- busy0, busy1  out  1  source register has an outstanding write (combinational).
- pending_count  out  L+1  number of registers currently busy.

## Operation
- Storage: regs[0..2**L-1], each N bits. The scoreboard is busy[0..2**L-1], one bit each.
- Reset (asserted, any time, independent of clk):
  - all regs = 0, all busy = 0, pending_count = 0.
  - Outputs follow combinationally: rd_data* = 0, busy* = 0.
- Write: on posedge clk with wr_ena=1, regs[wr_addr] <= wr_data. Ignored for address 0 when ZERO_REG=1.
- Read: rd_dataK = regs[rd_addrK]. Forced to 0 for address 0 when ZERO_REG=1. Both ports are independent and may use the same address.
- Scoreboard update on posedge clk:
  - wr_ena clears busy[wr_addr].
  - rsv_ena sets busy[rsv_addr].
  - Same address in the same cycle: set wins, so the register ends busy, the data is still written, and a younger reservation overrides an older completion.
  - Reserving an already-busy register keeps it busy with no count change.
  - wr_ena to a non-busy register writes the data and leaves busy at 0.
  - Address 0 is never set when ZERO_REG=1.
- busyK = busy[rd_addrK], subject to the bypass rule below.
- pending_count: registered popcount of busy, updated in the same edge as busy.
  - Range 0..2**L-1 with ZERO_REG=1, otherwise 0..2**L.
  - Increments by at most 1 and decrements by at most 1 per cycle; net 0 when both apply to different addresses that change state.

## Timing
- Read latency 0: combinational from rd_addr and from the current regs/busy.
- Write latency 1 edge: data written at edge k is readable after edge k (without bypass).
- Reservation: busy visible after the edge that samples rsv_ena.
- Writeback: busy clears after the edge that samples wr_ena.
- No handshake or backpressure: every asserted strobe is accepted.
- Reset deasserting mid-stream: first capture is the first rising edge with rst=0.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is compiled in.
  - If wr_ena=1, rd_addrK==wr_addr, and the address is nonzero (or ZERO_REG=0), then rd_dataK = wr_data and busyK = 0 in that same cycle.
  - If rsv_ena targets the same address in that cycle, busyK is still 0 this cycle; the bit sets at the edge.
- Undefined: no forwarding. rd_dataK shows the old value and busyK shows the stored bit until the write edge. Decode must stall one extra cycle.

## Test plan
- Reset: assert rst mid-run after writing x5=0xDEADBEEF and reserving x7 -> immediately rd_data0(x5)=0, busy for x7=0, pending_count=0.
- x0 behaviour (ZERO_REG=1): write 0x12345678 to x0 and rsv x0 -> rd_data0(x0)=0, busy0=0, pending_count unchanged.
- Scoreboard: rsv x3 at edge1, rsv x4 at edge2, wr x3=0xA5 at edge3:
  - after edge2: pending_count=2, busy(x3)=1.
  - after edge3: busy(x3)=0, rd(x3)=0xA5, pending_count=1.
- Simultaneous set/clear: x9 busy; in one cycle wr x9=0x55 and rsv x9 -> after edge: busy(x9)=1, rd(x9)=0x55, pending_count unchanged.
- Bypass, x6 holding 0x11 and busy:
  - wr_ena x6=0x22 with rd_addr1=6 before edge -> rd_data1=0x22, busy1=0 with REGFILE_BYPASS_EN.
  - Same stimulus without the macro -> rd_data1=0x11, busy1=1.
- Parameter sweep N=16, L=3: fill all 8 registers with distinct values, then read on both ports at the same and different addresses -> all values match. Reserve all 7 nonzero registers -> pending_count=7.

Source files
------------

// File: rtl/register_file_sb.sv
// Two-read/one-write flop register file with a per-register pending-write scoreboard.
// Optional write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module register_file_sb #(
  parameter int N        = 32,
  parameter int L        = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [L-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         rsv_ena,
  input  logic [L-1:0] rsv_addr,
  input  logic [L-1:0] rd_addr0,
  input  logic [L-1:0] rd_addr1,
  output logic [N-1:0] rd_data0,
  output logic [N-1:0] rd_data1,
  output logic         busy0,
  output logic         busy1,
  output logic [L:0]   pending_count
);

  localparam int DEPTH = 1 << L;

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             wr_hit;
  logic             rsv_hit;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [L-1:0]     rd_addr [2];
  logic [N-1:0]     rd_data [2];
  logic [1:0]       rd_busy;
  logic [1:0]       fwd;

  function automatic logic is_zero(input logic [L-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_hit  = wr_ena && !is_zero(wr_addr);
  assign rsv_hit = rsv_ena && !is_zero(rsv_addr);

  // Next scoreboard state; a reservation wins over a completion to the same register.
  always_comb begin
    cnt_inc = rsv_hit && !busy[rsv_addr];
    cnt_dec = wr_hit && busy[wr_addr] && !(rsv_hit && (rsv_addr == wr_addr));
    for (int i = 0; i < DEPTH; i++) begin
      busy_next[i] = (rsv_hit && (rsv_addr == L'(i))) ? 1'b1 :
                     (wr_hit  && (wr_addr  == L'(i))) ? 1'b0 : busy[i];
    end
  end

  // Storage, scoreboard and the running count of busy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy          <= '0;
      pending_count <= '0;
    end else begin
      if (wr_hit) begin
        regs[wr_addr] <= wr_data;
      end
      busy          <= busy_next;
      pending_count <= pending_count + (L+1)'(cnt_inc) - (L+1)'(cnt_dec);
    end
  end

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;

  // Combinational read ports with optional same-cycle forwarding of the writeback.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
`ifdef REGFILE_BYPASS_EN
      fwd[k] = wr_hit && (wr_addr == rd_addr[k]);
`else
      fwd[k] = 1'b0;
`endif
      rd_data[k] = fwd[k] ? wr_data :
                   (is_zero(rd_addr[k]) ? '0 : regs[rd_addr[k]]);
      rd_busy[k] = fwd[k] ? 1'b0 : busy[rd_addr[k]];
    end
  end

  assign rd_data0 = rd_data[0];
  assign rd_data1 = rd_data[1];
  assign busy0    = rd_busy[0];
  assign busy1    = rd_busy[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: default 32x32 instance plus an N=16, L=3 instance.
module tb_register_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we, re;
  logic [4:0]  wa, rsa, a0, a1;
  logic [31:0] wd, rd0, rd1;
  logic        b0, b1;
  logic [5:0]  cnt;

  logic        we2, re2;
  logic [2:0]  wa2, rsa2, a20, a21;
  logic [15:0] wd2, rd20, rd21;
  logic        b20, b21;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];

  logic [15:0] tbl [8] = '{16'h0F0F, 16'h1111, 16'h2222, 16'h3333,
                           16'h4444, 16'h5555, 16'h6666, 16'h7777};
  logic [2:0]  pa [6] = '{3'd1, 3'd2, 3'd7, 3'd3, 3'd6, 3'd0};
  logic [2:0]  pb [6] = '{3'd1, 3'd5, 3'd0, 3'd3, 3'd4, 3'd0};

  register_file_sb dut_a (
    .clk(clk), .rst(rst),
    .wr_ena(we), .wr_addr(wa), .wr_data(wd),
    .rsv_ena(re), .rsv_addr(rsa),
    .rd_addr0(a0), .rd_addr1(a1),
    .rd_data0(rd0), .rd_data1(rd1),
    .busy0(b0), .busy1(b1),
    .pending_count(cnt)
  );

  register_file_sb #(.N(16), .L(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .wr_ena(we2), .wr_addr(wa2), .wr_data(wd2),
    .rsv_ena(re2), .rsv_addr(rsa2),
    .rd_addr0(a20), .rd_addr1(a21),
    .rd_data0(rd20), .rd_data1(rd21),
    .busy0(b20), .busy1(b21),
    .pending_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                     input logic r, input logic [4:0] radr,
                     input logic [4:0] s0, input logic [4:0] s1);
    we = w; wa = wadr; wd = wdat; re = r; rsa = radr; a0 = s0; a1 = s1;
  endtask

  task automatic drv2(input logic w, input logic [2:0] wadr, input logic [15:0] wdat,
                      input logic r, input logic [2:0] radr,
                      input logic [2:0] s0, input logic [2:0] s1);
    we2 = w; wa2 = wadr; wd2 = wdat; re2 = r; rsa2 = radr; a20 = s0; a21 = s1;
  endtask

  task automatic chk(input string nm, input bit s, input logic [31:0] e0, input logic [31:0] e1,
                     input logic eb0, input logic eb1, input logic [5:0] ec);
    exp_t e;
    e.name = nm; e.sel = s; e.rd0 = e0; e.rd1 = e1; e.b0 = eb0; e.b1 = eb1; e.cnt = ec;
    q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops every queued expectation at the falling edge and compares.
  initial begin
    exp_t        e;
    logic [31:0] g0, g1;
    logic        gb0, gb1;
    logic [5:0]  gc;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        g0  = e.sel ? {16'h0000, rd20} : rd0;
        g1  = e.sel ? {16'h0000, rd21} : rd1;
        gb0 = e.sel ? b20 : b0;
        gb1 = e.sel ? b21 : b1;
        gc  = e.sel ? {2'b00, cnt2} : cnt;
        checks++;
        if ({g0, g1, gb0, gb1, gc} !== {e.rd0, e.rd1, e.b0, e.b1, e.cnt}) begin
          errors++;
          $display("FAIL %s: got rd0=%h rd1=%h b0=%b b1=%b cnt=%0d, want rd0=%h rd1=%h b0=%b b1=%b cnt=%0d",
                   e.name, g0, g1, gb0, gb1, gc, e.rd0, e.rd1, e.b0, e.b1, e.cnt);
        end
      end
    end
  end

  initial begin
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    drv2(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    #1;
    chk("reset_a", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    chk("reset_b", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;
    rst = 1'b0;

    drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 5'd5, 5'd7);
    chk("wr5_rsv7", 1'b0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
    chk("pre_reset", 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 6'd1);
    step;
    rst = 1'b1;
    chk("mid_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;
    rst = 1'b0;

    drv(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("x0_wr_rsv", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;

    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    chk("sb_edge1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
    chk("sb_edge2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 6'd1);
    step;
    drv(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd4);
    chk("sb_after2", 1'b0, BYP ? 32'hA5 : 32'h0, 32'h0, !BYP, 1'b1, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    chk("sb_after3", 1'b0, 32'hA5, 32'h0, 1'b0, 1'b1, 6'd1);
    step;

    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd4);
    chk("rsv9", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1);
    step;
    drv(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd4);
    chk("setclr9", 1'b0, BYP ? 32'h55 : 32'h0, 32'h0, !BYP, 1'b1, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd4);
    chk("setclr9_after", 1'b0, 32'h55, 32'h0, 1'b1, 1'b1, 6'd2);
    step;

    drv(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 5'd10, 5'd10);
    chk("wr_notbusy", 1'b0, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 1'b0, 1'b0, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd4);
    chk("wr_notbusy_after", 1'b0, 32'h77, 32'h0, 1'b0, 1'b1, 6'd2);
    step;

    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9);
    chk("rsv_busy", 1'b0, 32'h0, 32'h55, 1'b1, 1'b1, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    chk("rsv_busy_after", 1'b0, 32'h0, 32'h55, 1'b1, 1'b1, 6'd2);
    step;

    drv(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 5'd4, 5'd11);
    chk("net_zero", 1'b0, BYP ? 32'h44 : 32'h0, 32'h0, !BYP, 1'b0, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd11);
    chk("net_zero_after", 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 6'd2);
    step;

    drv(1'b1, 5'd6, 32'h11, 1'b0, 5'd0, 5'd6, 5'd6);
    chk("wr6", 1'b0, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, 1'b0, 1'b0, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 5'd6);
    chk("rsv6", 1'b0, 32'h11, 32'h11, 1'b0, 1'b0, 6'd2);
    step;
    drv(1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 5'd9, 5'd6);
    chk("bypass6", 1'b0, 32'h55, BYP ? 32'h22 : 32'h11, 1'b1, !BYP, 6'd3);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd6);
    chk("bypass6_after", 1'b0, 32'h55, 32'h22, 1'b1, 1'b0, 6'd2);
    step;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    for (int i = 0; i < 8; i++) begin
      drv2(1'b1, 3'(i), tbl[i], 1'b0, 3'd0, 3'd0, 3'd0);
      step;
    end
    for (int i = 0; i < 6; i++) begin
      drv2(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, pa[i], pb[i]);
      chk($sformatf("sweep_rd_%0d", i), 1'b1,
          {16'h0, (pa[i] == 3'd0) ? 16'h0 : tbl[pa[i]]},
          {16'h0, (pb[i] == 3'd0) ? 16'h0 : tbl[pb[i]]}, 1'b0, 1'b0, 6'd0);
      step;
    end
    for (int i = 1; i < 8; i++) begin
      drv2(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'd0, 3'd0);
      step;
    end
    drv2(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd7);
    chk("sweep_rsv7", 1'b1, 32'h0, {16'h0, tbl[7]}, 1'b0, 1'b1, 6'd7);
    step;
    drv2(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd7);
    chk("sweep_rsv_x0", 1'b1, 32'h0, {16'h0, tbl[7]}, 1'b0, 1'b1, 6'd7);
    step;
    step;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
